// File: rtl/segre_pkg.sv
// -----------------------------------------------------------------------------
// segre_pkg
// Shared constants and types for the Segre core memory path.
//   ADDR_SIZE        : byte address width
//   WORD_SIZE        : core word width
//   DCACHE_LANE_SIZE : data-cache lane width (one main-memory read transfer)
//   memop_data_type_e: access size of a store (BYTE / HALFWORD / WORD)
//   mm_fsm_state_e   : main-memory responder read FSM states
// Helper functions build the byte enables and the lane-replicated write data
// for a right-aligned store.
// -----------------------------------------------------------------------------
package segre_pkg;

  localparam int ADDR_SIZE        = 32;
  localparam int WORD_SIZE        = 32;
  localparam int DCACHE_LANE_SIZE = 128;

  localparam int WORD_BYTES = WORD_SIZE / 8;
  localparam int LANE_BYTES = DCACHE_LANE_SIZE / 8;
  localparam int LANE_WORDS = DCACHE_LANE_SIZE / WORD_SIZE;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    MM_IDLE = 2'b00,
    MM_WAIT = 2'b01,
    MM_RESP = 2'b10
  } mm_fsm_state_e;

  // Byte enables inside one word; low address bits the size makes
  // irrelevant are ignored (a[0] for halfwords, a[1:0] for words).
  function automatic logic [WORD_BYTES-1:0] mm_byte_en(
    input memop_data_type_e t,
    input logic [1:0]       a
  );
    logic [WORD_BYTES-1:0] be;
    case (t)
      BYTE:     be = 4'b0001 << a;
      HALFWORD: be = a[1] ? 4'b1100 : 4'b0011;
      WORD:     be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data across the word so the byte
  // enables alone select the destination bytes.
  function automatic logic [WORD_SIZE-1:0] mm_wr_align(
    input memop_data_type_e     t,
    input logic [WORD_SIZE-1:0] d
  );
    logic [WORD_SIZE-1:0] w;
    case (t)
      BYTE:     w = {4{d[7:0]}};
      HALFWORD: w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/segre_mm_storage.sv
// -----------------------------------------------------------------------------
// segre_mm_storage
// Byte-enabled word array backing the main memory. One synchronous write
// port (word index + byte enables) and one asynchronous lane-wide read port.
// Contents are never reset.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_word_i  : word index to write
//   wr_be_i    : per-byte write enables within the word
//   wr_data_i  : write data, already placed in its byte positions
//   rd_lane_i  : lane index to read
//   rd_data_o  : lane contents, word 0 in the low bits
// -----------------------------------------------------------------------------
module segre_mm_storage
  import segre_pkg::*;
#(
  parameter int MEM_SIZE = 65536
) (
  input  logic                                          clk_i,
  input  logic                                          wr_en_i,
  input  logic [$clog2(MEM_SIZE/WORD_BYTES)-1:0]        wr_word_i,
  input  logic [WORD_BYTES-1:0]                         wr_be_i,
  input  logic [WORD_SIZE-1:0]                          wr_data_i,
  input  logic [$clog2(MEM_SIZE/LANE_BYTES)-1:0]        rd_lane_i,
  output logic [DCACHE_LANE_SIZE-1:0]                   rd_data_o
);

  localparam int NUM_WORDS = MEM_SIZE / WORD_BYTES;
  localparam int WOFF_W    = $clog2(LANE_WORDS);

  logic [WORD_SIZE-1:0] r_mem [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (wr_be_i[b]) r_mem[wr_word_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  // Combinational lane read: a same-edge write is not yet in the array, so
  // a register sampling this lane sees read-before-write.
  for (genvar g = 0; g < LANE_WORDS; g++) begin : g_rd
    assign rd_data_o[g*WORD_SIZE +: WORD_SIZE] = r_mem[{rd_lane_i, WOFF_W'(g)}];
  end

endmodule

// File: rtl/segre_main_memory.sv
// -----------------------------------------------------------------------------
// segre_main_memory
// Main-memory responder for the Segre core. Reads return a full lane after a
// fixed latency; writes (byte/halfword/word) commit on the edge they are
// presented, in any FSM state.
// Ports:
//   clk_i          : clock
//   rsn_i          : asynchronous active-low reset
//   rd_i           : read request, sampled only in IDLE
//   addr_i         : read address (lane aligned internally)
//   rd_data_o      : returned lane, registered on RESP entry, held until next RESP
//   data_rdy_o     : one-cycle pulse, rd_data_o valid
//   wr_i           : write request
//   wr_addr_i      : write byte address
//   wr_data_i      : right-aligned write data
//   wr_data_type_i : BYTE / HALFWORD / WORD
//   busy_o         : high while a read is in flight (WAIT, RESP)
//   mm_err_o       : out-of-range access pulse (only with SEGRE_MM_BOUNDS_EN)
// Build option SEGRE_MM_BOUNDS_EN: addresses at/above MEM_SIZE are rejected
// (writes dropped, reads return zero) and flagged on mm_err_o. Without it,
// addresses wrap modulo MEM_SIZE.
// -----------------------------------------------------------------------------
module segre_main_memory
  import segre_pkg::*;
#(
  parameter int MEM_SIZE   = 65536,
  parameter int RD_LATENCY = 10
) (
  input  logic                        clk_i,
  input  logic                        rsn_i,
  input  logic                        rd_i,
  input  logic [ADDR_SIZE-1:0]        addr_i,
  output logic [DCACHE_LANE_SIZE-1:0] rd_data_o,
  output logic                        data_rdy_o,
  input  logic                        wr_i,
  input  logic [ADDR_SIZE-1:0]        wr_addr_i,
  input  logic [WORD_SIZE-1:0]        wr_data_i,
  input  memop_data_type_e            wr_data_type_i,
  output logic                        busy_o
`ifdef SEGRE_MM_BOUNDS_EN
  ,
  output logic                        mm_err_o
`endif
);

  localparam int MEM_AW   = $clog2(MEM_SIZE);
  localparam int LANE_OFF = $clog2(LANE_BYTES);
  localparam int LIDX_W   = MEM_AW - LANE_OFF;
  localparam int WIDX_W   = MEM_AW - 2;
  localparam int CNT_W    = $clog2(RD_LATENCY + 1);
  // The IDLE->WAIT edge and the WAIT->RESP edge together account for two
  // cycles of latency, hence the -2.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

  mm_fsm_state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [LIDX_W-1:0]           r_rd_lane;
  logic [DCACHE_LANE_SIZE-1:0] r_rd_data;
  logic [DCACHE_LANE_SIZE-1:0] w_lane;
  logic [WORD_BYTES-1:0]       w_be;
  logic [WORD_SIZE-1:0]        w_wdata;
  logic                        w_wr_en;
  logic                        w_rd_take;
  logic                        w_resp_entry;

  assign w_rd_take    = (r_state == MM_IDLE) && rd_i;
  assign w_resp_entry = (r_state != MM_RESP) && (w_state_nxt == MM_RESP);

  // ---------------------------------------------------------------------------
  // Address range handling
  // ---------------------------------------------------------------------------
`ifdef SEGRE_MM_BOUNDS_EN
  logic w_wr_oor, w_rd_oor;
  logic r_rd_oor, r_wr_err;

  assign w_wr_oor = |(wr_addr_i >> MEM_AW);
  assign w_rd_oor = |(addr_i >> MEM_AW);
  assign w_wr_en  = wr_i && !w_wr_oor;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_rd_oor <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_i && w_wr_oor;
      if (w_rd_take) r_rd_oor <= w_rd_oor;
    end
  end

  // Read errors are reported alongside data_rdy_o, write errors the cycle
  // after the rejected write.
  assign mm_err_o = r_wr_err || ((r_state == MM_RESP) && r_rd_oor);

  logic w_unused;
  assign w_unused = ^addr_i[LANE_OFF-1:0];
`else
  assign w_wr_en = wr_i;

  // Upper address bits are dropped (wrap) and lane-offset bits are unused.
  logic w_unused;
  assign w_unused = ^{addr_i[ADDR_SIZE-1:MEM_AW], addr_i[LANE_OFF-1:0],
                      wr_addr_i[ADDR_SIZE-1:MEM_AW]};
`endif

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  assign w_be    = mm_byte_en(wr_data_type_i, wr_addr_i[1:0]);
  assign w_wdata = mm_wr_align(wr_data_type_i, wr_data_i);

  segre_mm_storage #(
    .MEM_SIZE (MEM_SIZE)
  ) u_storage (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_en),
    .wr_word_i (wr_addr_i[2 +: WIDX_W]),
    .wr_be_i   (w_be),
    .wr_data_i (w_wdata),
    .rd_lane_i (r_rd_lane),
    .rd_data_o (w_lane)
  );

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state <= MM_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MM_IDLE: begin
        if (rd_i) begin
          if (RD_LATENCY == 1) begin
            w_state_nxt = MM_RESP;
          end else begin
            w_state_nxt = MM_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      MM_WAIT: begin
        if (r_cnt == '0) w_state_nxt = MM_RESP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      MM_RESP: w_state_nxt = MM_IDLE;
      default: w_state_nxt = MM_IDLE;
    endcase
  end

  // Lane index is latched at the request; the lane data itself is sampled
  // only on RESP entry so writes during WAIT are returned.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_rd_lane <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_rd_take) r_rd_lane <= addr_i[LANE_OFF +: LIDX_W];
`ifdef SEGRE_MM_BOUNDS_EN
      if (w_resp_entry) r_rd_data <= r_rd_oor ? '0 : w_lane;
`else
      if (w_resp_entry) r_rd_data <= w_lane;
`endif
    end
  end

  assign rd_data_o  = r_rd_data;
  assign data_rdy_o = (r_state == MM_RESP);
  assign busy_o     = (r_state != MM_IDLE);

endmodule

// File: tb/tb_segre_main_memory.sv
module tb_segre_main_memory;
  import segre_pkg::*;

  localparam int MEM = 65536;
  localparam int LAT = 10;

  logic                        clk = 1'b0;
  logic                        rsn;
  logic                        rd;
  logic [ADDR_SIZE-1:0]        addr;
  logic [DCACHE_LANE_SIZE-1:0] rd_data;
  logic                        rdy;
  logic                        wr;
  logic [ADDR_SIZE-1:0]        wr_addr;
  logic [WORD_SIZE-1:0]        wr_data;
  memop_data_type_e            wr_type;
  logic                        busy;
`ifdef SEGRE_MM_BOUNDS_EN
  logic                        mm_err;
`endif

  always #5 clk = ~clk;

  segre_main_memory #(.MEM_SIZE(MEM), .RD_LATENCY(LAT)) dut (
    .clk_i          (clk),
    .rsn_i          (rsn),
    .rd_i           (rd),
    .addr_i         (addr),
    .rd_data_o      (rd_data),
    .data_rdy_o     (rdy),
    .wr_i           (wr),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .wr_data_type_i (wr_type),
    .busy_o         (busy)
`ifdef SEGRE_MM_BOUNDS_EN
    ,
    .mm_err_o       (mm_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Byte-level reference memory; only bytes ever written are known.
  logic [7:0] mdl [int];

  typedef struct {
    logic [127:0] data;
    logic [127:0] mask;
    logic         oor;
  } sb_t;
  sb_t sbq[$];

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(MEM);
  endfunction

  task automatic mdl_write(input memop_data_type_e t, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ea;
`ifdef SEGRE_MM_BOUNDS_EN
    if (!in_range(a)) return;
`endif
    ea = a & 32'(MEM - 1);
    case (t)
      BYTE: mdl[int'(ea)] = d[7:0];
      HALFWORD: begin
        mdl[int'(ea & ~32'h1)]      = d[7:0];
        mdl[int'((ea & ~32'h1) + 1)] = d[15:8];
      end
      default:
        for (int b = 0; b < 4; b++) mdl[int'((ea & ~32'h3) + 32'(b))] = d[b*8 +: 8];
    endcase
  endtask

  task automatic do_write(input memop_data_type_e t, input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; wr_type = t; wr_addr = a; wr_data = d;
    mdl_write(t, a, d);
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input string name, output logic [127:0] got);
    sb_t   e;
    sb_t   p;
    int    k;
    logic  seen;
    logic [31:0] base;
    e.data = '0; e.mask = '0; e.oor = 1'b0;
`ifdef SEGRE_MM_BOUNDS_EN
    e.oor = !in_range(a);
`endif
    if (e.oor) begin
      e.mask = '1;
    end else begin
      base = (a & 32'(MEM - 1)) & ~32'hF;
      for (int b = 0; b < 16; b++) begin
        if (mdl.exists(int'(base + 32'(b)))) begin
          e.data[b*8 +: 8] = mdl[int'(base + 32'(b))];
          e.mask[b*8 +: 8] = 8'hFF;
        end
      end
    end
    sbq.push_back(e);
    rd = 1'b1; addr = a;
    @(posedge clk); #1;
    rd = 1'b0;
    seen = 1'b0;
    for (k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk);
    end
    p = sbq.pop_front();
    got = rd_data;
    if (!seen) begin
      chk({name, " rdy timeout"}, 0, 1);
    end else begin
      chk({name, " latency"}, k, LAT - 1);
      chk({name, " lane"}, rd_data & p.mask, p.data & p.mask);
`ifdef SEGRE_MM_BOUNDS_EN
      chk({name, " err"}, mm_err, p.oor);
`endif
      @(posedge clk); @(negedge clk);
      chk({name, " pulse end"}, {busy, rdy}, 2'b00);
    end
  endtask

  typedef struct {
    memop_data_type_e t;
    logic [31:0]      wa;
    logic [31:0]      wd;
    logic [31:0]      ra;
    int               widx;
    logic [31:0]      ew;
  } vec_t;
  vec_t vt[10];

  logic [127:0] got;
  int           pulses, p1, p2;

  initial begin
    vt[0] = '{WORD,     32'h100,   32'hDEADBEEF, 32'h10C,  0, 32'hDEADBEEF};
    vt[1] = '{WORD,     32'h200,   32'h11223344, 32'h200,  0, 32'h11223344};
    vt[2] = '{BYTE,     32'h201,   32'h000000AA, 32'h200,  0, 32'h1122AA44};
    vt[3] = '{HALFWORD, 32'h202,   32'hFFFFBBCC, 32'h200,  0, 32'hBBCCAA44};
    vt[4] = '{WORD,     32'h20C,   32'h00000000, 32'h208,  3, 32'h00000000};
    vt[5] = '{BYTE,     32'h20F,   32'hFFFFFF5A, 32'h200,  3, 32'h5A000000};
    vt[6] = '{HALFWORD, 32'h20D,   32'h00001234, 32'h200,  3, 32'h5A001234};
    vt[7] = '{HALFWORD, 32'h20F,   32'h00007788, 32'h204,  3, 32'h77881234};
    vt[8] = '{WORD,     32'h203,   32'hCAFEF00D, 32'h200,  0, 32'hCAFEF00D};
    vt[9] = '{WORD,     32'hFFFC,  32'h00000055, 32'hFFF0, 3, 32'h00000055};

    rsn = 1'b0; rd = 1'b0; addr = '0; wr = 1'b0; wr_addr = '0; wr_data = '0; wr_type = WORD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outs", {busy, rdy}, 2'b00);
    chk("reset rd_data", rd_data, '0);
`ifdef SEGRE_MM_BOUNDS_EN
    chk("reset err", mm_err, 0);
`endif
    rsn = 1'b1;
    @(posedge clk); #1;

    // Table-driven write/readback
    for (int i = 0; i < 10; i++) begin
      do_write(vt[i].t, vt[i].wa, vt[i].wd);
      do_read(vt[i].ra, $sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d word", i), got[vt[i].widx*32 +: 32], vt[i].ew);
    end

    // Writes during an in-flight read: visible until the RESP-entry edge.
    do_write(WORD, 32'h304, 32'h11111111);
    do_write(WORD, 32'h308, 32'h00000000);
    rd = 1'b1; addr = 32'h300;
    @(posedge clk); #1;
    rd = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      if (k == 3) begin
        wr = 1'b1; wr_type = WORD; wr_addr = 32'h304; wr_data = 32'h55;
      end else if (k == LAT - 1) begin
        wr = 1'b1; wr_type = WORD; wr_addr = 32'h308; wr_data = 32'h99;
      end
      @(posedge clk); #1;
      wr = 1'b0;
    end
    @(negedge clk);
    chk("inflight rdy", rdy, 1);
    chk("inflight w1", rd_data[63:32], 32'h55);
    chk("inflight w2", rd_data[95:64], 32'h0);
    mdl_write(WORD, 32'h304, 32'h55);
    mdl_write(WORD, 32'h308, 32'h99);
    @(posedge clk); #1;
    do_read(32'h300, "after inflight", got);
    chk("after inflight w2", got[95:64], 32'h99);

    // rd_i held through RESP: re-sampled in the following IDLE cycle.
    rd = 1'b1; addr = 32'h100;
    pulses = 0; p1 = -1; p2 = -1;
    for (int k = 0; k < 3 * LAT; k++) begin
      @(posedge clk); @(negedge clk);
      if (rdy) begin
        pulses++;
        if (pulses == 1) p1 = k;
        else if (pulses == 2) begin p2 = k; rd = 1'b0; end
      end
    end
    rd = 1'b0;
    chk("held pulses", pulses, 2);
    chk("held first", p1, LAT - 1);
    chk("held second", p2, 2 * LAT);
    chk("held data", rd_data[31:0], 32'hDEADBEEF);

    // rd_i pulsed while in WAIT is ignored.
    #1;
    rd = 1'b1; addr = 32'h200;
    pulses = 0;
    for (int k = 0; k < 2 * LAT + 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) rd = 1'b0;
      if (k == 3) rd = 1'b1;
      if (k == 4) rd = 1'b0;
      @(negedge clk);
      if (rdy) pulses++;
    end
    chk("wait rd ignored", pulses, 1);

    // Reset mid-WAIT discards the read; storage survives.
    @(posedge clk); #1;
    rd = 1'b1; addr = 32'h200;
    @(posedge clk); #1;
    rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rsn = 1'b0;
    #1;
    chk("async reset outs", {busy, rdy}, 2'b00);
    chk("async reset data", rd_data, '0);
    @(negedge clk);
    rsn = 1'b1;
    pulses = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    chk("no rdy after reset", pulses, 0);
    @(posedge clk); #1;
    do_read(32'h100, "post reset", got);
    chk("post reset word", got[31:0], 32'hDEADBEEF);

    // Out-of-range / wrap behaviour
`ifdef SEGRE_MM_BOUNDS_EN
    do_write(WORD, 32'h0, 32'h12345678);
    @(negedge clk);
    chk("inrange wr err", mm_err, 0);
    wr = 1'b1; wr_type = WORD; wr_addr = 32'h10000; wr_data = 32'hFFFFFFFF;
    mdl_write(WORD, 32'h10000, 32'hFFFFFFFF);
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("oor wr err", mm_err, 1);
    @(negedge clk);
    chk("oor wr err end", mm_err, 0);
    @(posedge clk); #1;
    do_read(32'h0, "oor keep", got);
    chk("oor keep word", got[31:0], 32'h12345678);
    do_read(32'h10000, "oor read", got);
    chk("oor read lane", got, '0);
`else
    do_write(WORD, 32'h0, 32'h12345678);
    do_write(WORD, 32'h10000, 32'hA5A5A5A5);
    do_read(32'h0, "wrap", got);
    chk("wrap word", got[31:0], 32'hA5A5A5A5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
